// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: qualifies HDU stall/flush requests against the
// EX valid bit and derives per-stage write enables, valid bits and perf counters.
module pipe_ctrl #(
  parameter int RESET_HOLD = 2,
  parameter int CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             STALL,
  input  logic             FLUSH,
  input  logic             MEM_BUSY,
  output logic             PC_WE,
  output logic             IF_DE_WE,
  output logic             DE_EX_WE,
  output logic             EX_MEM_WE,
  output logic             MEM_WB_WE,
  output logic             DE_valid,
  output logic             EX_valid,
  output logic             MEM_valid,
  output logic             WB_valid,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [3:0]       hold_q;
  logic             de_v_q, ex_v_q, mem_v_q, wb_v_q;
  logic             de_v_d, ex_v_d, mem_v_d, wb_v_d;
  logic [CNT_W-1:0] cyc_q, ret_q, stl_q, fl_q;

  logic run, stall_ok, flush_ok;
  logic freeze, redirect, bubble, advance;

  // A request from a squashed bubble in EX must never stall or redirect.
  assign run      = (state_q == RUN);
  assign stall_ok = STALL & ex_v_q;
  assign flush_ok = FLUSH & ex_v_q;
  assign freeze   = run & MEM_BUSY;
  assign redirect = run & ~MEM_BUSY & flush_ok;
  assign bubble   = run & ~MEM_BUSY & ~flush_ok & stall_ok;
  assign advance  = run & ~MEM_BUSY & ~flush_ok & ~stall_ok;

  assign PC_WE     = redirect | advance;
  assign IF_DE_WE  = redirect | advance;
  assign DE_EX_WE  = redirect | bubble | advance;
  assign EX_MEM_WE = redirect | bubble | advance;
  assign MEM_WB_WE = redirect | bubble | advance;

  always_comb begin
    de_v_d  = de_v_q;
    ex_v_d  = ex_v_q;
    mem_v_d = mem_v_q;
    wb_v_d  = wb_v_q;
    if (redirect) begin
      de_v_d  = 1'b0;
      ex_v_d  = 1'b0;
      mem_v_d = ex_v_q;
      wb_v_d  = mem_v_q;
    end else if (bubble) begin
      ex_v_d  = 1'b0;
      mem_v_d = ex_v_q;
      wb_v_d  = mem_v_q;
    end else if (advance) begin
      de_v_d  = 1'b1;
      ex_v_d  = de_v_q;
      mem_v_d = ex_v_q;
      wb_v_d  = mem_v_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      hold_q  <= 4'(RESET_HOLD - 1);
      de_v_q  <= 1'b0;
      ex_v_q  <= 1'b0;
      mem_v_q <= 1'b0;
      wb_v_q  <= 1'b0;
      cyc_q   <= '0;
      ret_q   <= '0;
      stl_q   <= '0;
      fl_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hold_q == 4'd0) state_q <= RUN;
          else                hold_q  <= hold_q - 4'd1;
        end
        RUN: begin
          de_v_q  <= de_v_d;
          ex_v_q  <= ex_v_d;
          mem_v_q <= mem_v_d;
          wb_v_q  <= wb_v_d;
          cyc_q   <= cyc_q + CNT_W'(1);
          if (wb_v_q && !MEM_BUSY) ret_q <= ret_q + CNT_W'(1);
          if (bubble || freeze)    stl_q <= stl_q + CNT_W'(1);
          if (redirect)            fl_q  <= fl_q + CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign DE_valid  = de_v_q;
  assign EX_valid  = ex_v_q;
  assign MEM_valid = mem_v_q;
  assign WB_valid  = wb_v_q;
  assign cyc_cnt   = cyc_q;
  assign ret_cnt   = ret_q;
  assign stall_cnt = stl_q;
  assign flush_cnt = fl_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: each driven cycle pushes its hand-computed
// expectation; a negedge monitor pops and compares against the DUT outputs.
module tb_pipe_ctrl;

  localparam int CNT_W = 32;

  logic CLK = 1'b0;
  logic RST, STALL, FLUSH, MEM_BUSY;
  logic PC_WE, IF_DE_WE, DE_EX_WE, EX_MEM_WE, MEM_WB_WE;
  logic DE_valid, EX_valid, MEM_valid, WB_valid;
  logic [CNT_W-1:0] cyc_cnt, ret_cnt, stall_cnt, flush_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         row;
    logic [4:0] we;
    logic [3:0] v;
    int         cyc, ret, stl, fl;
  } exp_t;

  exp_t sb[$];

  pipe_ctrl #(.RESET_HOLD(2), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH), .MEM_BUSY(MEM_BUSY),
    .PC_WE(PC_WE), .IF_DE_WE(IF_DE_WE), .DE_EX_WE(DE_EX_WE),
    .EX_MEM_WE(EX_MEM_WE), .MEM_WB_WE(MEM_WB_WE),
    .DE_valid(DE_valid), .EX_valid(EX_valid), .MEM_valid(MEM_valid), .WB_valid(WB_valid),
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s row=%0d actual=%0h required=%0h", name, row, act, req);
    end
  endtask

  // Monitor: the DUT presents a fresh output set every cycle.
  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("we",    e.row, {27'd0, PC_WE, IF_DE_WE, DE_EX_WE, EX_MEM_WE, MEM_WB_WE}, {27'd0, e.we});
      chk("valid", e.row, {28'd0, DE_valid, EX_valid, MEM_valid, WB_valid}, {28'd0, e.v});
      chk("cyc",   e.row, cyc_cnt,   e.cyc);
      chk("ret",   e.row, ret_cnt,   e.ret);
      chk("stall", e.row, stall_cnt, e.stl);
      chk("flush", e.row, flush_cnt, e.fl);
    end
  end

  int rown = 0;

  // ctl = {RST, STALL, FLUSH, MEM_BUSY}
  task automatic step(input logic [3:0] ctl, input logic [4:0] we, input logic [3:0] v,
                      input int cyc, input int ret, input int stl, input int fl);
    exp_t e;
    @(posedge CLK);
    #1;
    {RST, STALL, FLUSH, MEM_BUSY} = ctl;
    e.row = rown; e.we = we; e.v = v;
    e.cyc = cyc; e.ret = ret; e.stl = stl; e.fl = fl;
    sb.push_back(e);
    rown++;
  endtask

  initial begin
    RST = 1'b1; STALL = 1'b0; FLUSH = 1'b0; MEM_BUSY = 1'b0;
    repeat (2) @(posedge CLK);
    //       ctl      we        valids   cyc ret stl fl
    step(4'b1000, 5'b00000, 4'b0000,  0,  0, 0, 0);  // reset held
    step(4'b0000, 5'b00000, 4'b0000,  0,  0, 0, 0);  // IDLE hold 1
    step(4'b0000, 5'b00000, 4'b0000,  0,  0, 0, 0);  // IDLE hold 0
    step(4'b0000, 5'b11111, 4'b0000,  0,  0, 0, 0);  // first ADVANCE
    step(4'b0000, 5'b11111, 4'b1000,  1,  0, 0, 0);
    step(4'b0000, 5'b11111, 4'b1100,  2,  0, 0, 0);
    step(4'b0000, 5'b11111, 4'b1110,  3,  0, 0, 0);
    step(4'b0000, 5'b11111, 4'b1111,  4,  0, 0, 0);  // pipe full
    step(4'b0100, 5'b00111, 4'b1111,  5,  1, 0, 0);  // load-use BUBBLE
    step(4'b0000, 5'b11111, 4'b1011,  6,  2, 1, 0);
    step(4'b0000, 5'b11111, 4'b1101,  7,  3, 1, 0);
    step(4'b0000, 5'b11111, 4'b1110,  8,  4, 1, 0);  // bubble in WB: ret misses
    step(4'b0010, 5'b11111, 4'b1111,  9,  4, 1, 0);  // branch REDIRECT
    step(4'b0110, 5'b11111, 4'b0011, 10,  5, 1, 1);  // stale stall+flush
    step(4'b0000, 5'b11111, 4'b1001, 11,  6, 1, 1);
    step(4'b0000, 5'b11111, 4'b1100, 12,  7, 1, 1);
    step(4'b0000, 5'b11111, 4'b1110, 13,  7, 1, 1);
    step(4'b0110, 5'b11111, 4'b1111, 14,  7, 1, 1);  // flush+stall together
    step(4'b0000, 5'b11111, 4'b0011, 15,  8, 1, 2);
    step(4'b0000, 5'b11111, 4'b1001, 16,  9, 1, 2);
    step(4'b0000, 5'b11111, 4'b1100, 17, 10, 1, 2);
    step(4'b0000, 5'b11111, 4'b1110, 18, 10, 1, 2);
    step(4'b0101, 5'b00000, 4'b1111, 19, 10, 1, 2);  // FREEZE with stall
    step(4'b0101, 5'b00000, 4'b1111, 20, 10, 2, 2);
    step(4'b1101, 5'b00000, 4'b1111, 21, 10, 3, 2);  // mid-freeze reset
    step(4'b0000, 5'b00000, 4'b0000,  0,  0, 0, 0);
    step(4'b0000, 5'b00000, 4'b0000,  0,  0, 0, 0);
    step(4'b0000, 5'b11111, 4'b0000,  0,  0, 0, 0);  // RUN again
    repeat (3) @(posedge CLK);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage Otter core. It sits downstream of the hazard detection unit and turns its raw STALL and FLUSH requests, plus the data-memory busy signal, into per-stage register write enables and per-stage valid bits. It qualifies hazard requests against instruction validity so that squashed bubbles never stall or redirect the core. It also holds the core idle for a fixed number of cycles after reset and keeps performance counters.

## Interface
- RESET_HOLD, default 2: cycles held in IDLE after reset is released (legal range 1–15).
- CNT_W, default 32: width of each performance counter.

- CLK  in  1  core clock.
- RST  in  1  synchronous, active-high reset.
- STALL  in  1  load-use stall request from the HDU (refers to the instruction in EX).
- FLUSH  in  1  control-redirect request from the HDU (branch/jump resolved in EX).
- MEM_BUSY  in  1  data memory has not completed the access in MEM; the whole pipeline must freeze.
- PC_WE  out  1  PC register write enable.
- IF_DE_WE  out  1  IF/DE pipeline register write enable.
- DE_EX_WE  out  1  DE/EX register write enable.
- EX_MEM_WE  out  1  EX/MEM register write enable.
- MEM_WB_WE  out  1  MEM/WB register write enable.
- DE_valid, EX_valid, MEM_valid, WB_valid  out  1 each  registered valid bit of the instruction currently in that stage.
- cyc_cnt, ret_cnt, stall_cnt, flush_cnt  out  CNT_W each  performance counters.

## Operation
- FSM states: IDLE and RUN. RST forces IDLE, loads hold counter with RESET_HOLD-1, clears all valids and counters.
- IDLE: all WE = 0; valids stay 0. Hold counter decrements each cycle; at 0 go to RUN on the next edge. Counters do not count in IDLE.
- RUN: qualified requests: stall_q = STALL & EX_valid; flush_q = FLUSH & EX_valid. Priority per cycle, highest first:
  - FREEZE (MEM_BUSY=1): all WE = 0; all valids hold.
  - REDIRECT (flush_q): all WE = 1; next DE_valid = 0, EX_valid = 0, MEM_valid = EX_valid, WB_valid = MEM_valid. The PC loads the target. FLUSH has priority over STALL in the same cycle.
  - BUBBLE (stall_q): PC_WE = IF_DE_WE = 0. DE_EX_WE = EX_MEM_WE = MEM_WB_WE = 1. Next EX_valid = 0 (the bubble), MEM_valid = EX_valid, WB_valid = MEM_valid, DE_valid holds.
  - ADVANCE: all WE = 1; next DE_valid = 1, EX_valid = DE_valid, MEM_valid = EX_valid, WB_valid = MEM_valid.
- An unqualified STALL or FLUSH (EX_valid = 0) is ignored and treated as ADVANCE. It is not counted.
- Counters, in RUN only, each saturating-free (wrap modulo 2^CNT_W):
  - cyc_cnt +1 every cycle.
  - ret_cnt +1 when WB_valid=1 & MEM_BUSY=0.
  - stall_cnt +1 on BUBBLE or FREEZE cycles.
  - flush_cnt +1 on REDIRECT cycles.
- RST asserted mid-operation: on that same edge, return to IDLE with all valids and counters = 0, regardless of MEM_BUSY, STALL or FLUSH.

## Timing
- WE outputs are combinational from the FSM state, the registered valids, and the current STALL, FLUSH and MEM_BUSY. There are no extra registers. Pipeline registers consume them at the same CLK edge.
- Valids, counters and the FSM update on the rising CLK edge. Results are visible the cycle after the triggering condition.
- Reset values: all WE = 0 (IDLE), all valids = 0, all counters = 0.
- First ADVANCE occurs in the cycle after RESET_HOLD IDLE cycles. DE_valid rises one cycle later.
- A REDIRECT costs exactly 2 bubbles. A BUBBLE costs exactly 1 cycle per qualified STALL cycle.
- A FREEZE of N cycles delays everything by exactly N cycles. Any state on entry is preserved unchanged.

## Test plan
- Reset/startup: RST 1 cycle, RESET_HOLD=2 -> WE=0 for 2 cycles, then all WE=1. DE_valid=1 one cycle later and WB_valid=1 four cycles later. cyc_cnt=0 throughout IDLE.
- Load-use: with the pipe full, STALL=1 for 1 cycle -> that cycle PC_WE=IF_DE_WE=0 and DE_EX_WE=1. Next cycle EX_valid=0 and DE_valid=1. stall_cnt=1, and ret_cnt shows one missing increment 3 cycles later.
- Branch taken: with the pipe full, FLUSH=1 for 1 cycle -> next DE_valid=0, EX_valid=0, MEM_valid=1. flush_cnt=1. Exactly 2 retirements are skipped.
- FLUSH and STALL together in the same cycle -> REDIRECT behaviour only. flush_cnt +1, stall_cnt unchanged.
- Stale request: drive STALL=1 and FLUSH=1 while EX_valid=0, for example in the cycle after a flush -> ADVANCE: all WE=1 and no counter change except cyc_cnt.
- MEM_BUSY for 3 cycles with STALL=1 and mid-freeze RST -> WE=0 while busy, valids hold, stall_cnt counts the busy cycles. RST clears all valids and counters on the next edge and the FSM returns to IDLE.
